// File: rtl/VX_gpu_pkg.sv
// Shared constants for the PE commit sequencer and its order FIFO.
package VX_gpu_pkg;

  // Width of the optional head-of-line stall counter (PE_SEQ_PERF_EN builds)
  localparam int PE_SEQ_PERF_W = 32;

  // Cycles a PE may offer a beat into an empty order FIFO before the sim warning
  localparam int PE_SEQ_STARVE_LIMIT = 1000;

endpackage

// File: rtl/pe_order_fifo.sv
// Circular buffer of PE selects in issue order, with a registered push-space flag.
module pe_order_fifo
  import VX_gpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             can_push,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];
  assign count     = count_q;

  // Next occupancy; a simultaneous push and pop cancel out
  always_comb begin
    count_next = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Select storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and push-space flag; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      can_push <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q  <= count_next;
      can_push <= (count_next != FULL_CNT);
    end
  end

endmodule

// File: rtl/pe_commit_sequencer.sv
// In-order commit sequencer: drains per-PE commit streams in request issue order.
// Optional feature macro: PE_SEQ_PERF_EN adds the perf_hol_stalls counter port.
module pe_commit_sequencer
  import VX_gpu_pkg::*;
#(
  parameter int PE_COUNT    = 2,
  parameter int DATAW       = 64,
  parameter int ORDER_DEPTH = 8,
  parameter int PE_SEL_W    = $clog2(PE_COUNT),
  parameter int CNT_W       = $clog2(ORDER_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  input  logic [PE_SEL_W-1:0]       req_sel,
  output logic                      req_ready,
  input  logic [PE_COUNT-1:0]       pe_rsp_valid,
  input  logic [PE_COUNT*DATAW-1:0] pe_rsp_data,
  input  logic [PE_COUNT-1:0]       pe_rsp_eop,
  output logic [PE_COUNT-1:0]       pe_rsp_ready,
  output logic                      commit_valid,
  output logic [DATAW-1:0]          commit_data,
  output logic                      commit_eop,
  input  logic                      commit_ready,
  output logic [CNT_W-1:0]          outstanding
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [PE_SEQ_PERF_W-1:0]  perf_hol_stalls
`endif
);

  localparam logic [PE_SEL_W:0] SEL_LIMIT = (PE_SEL_W + 1)'(PE_COUNT);

  logic                req_in_range;
  logic                push;
  logic                pop;
  logic [PE_SEL_W-1:0] head_sel;
  logic                empty;
  logic                can_push;
  logic                out_free;
  logic [PE_COUNT-1:0] head_mask;
  logic                head_valid;
  logic                head_eop;
  logic [DATAW-1:0]    head_data;
  logic                head_fire;

  // Out-of-range selects still complete the handshake but are never recorded
  assign req_in_range = ({1'b0, req_sel} < SEL_LIMIT);
  assign req_ready    = can_push;
  assign push         = req_valid && req_ready && req_in_range;

  pe_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (PE_SEL_W),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (req_sel),
    .pop       (pop),
    .head_data (head_sel),
    .empty     (empty),
    .can_push  (can_push),
    .count     (outstanding)
  );

  // Head mux: pick the beat of the PE whose request is oldest
  always_comb begin
    head_mask  = '0;
    head_valid = 1'b0;
    head_eop   = 1'b0;
    head_data  = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (PE_SEL_W'(i) == head_sel) begin
        head_mask[i] = 1'b1;
        head_valid   = pe_rsp_valid[i];
        head_eop     = pe_rsp_eop[i];
        head_data    = pe_rsp_data[i*DATAW +: DATAW];
      end
    end
  end

  // Only the head PE is accepted, and only when the output register can take a beat
  assign out_free     = !commit_valid || commit_ready;
  assign pe_rsp_ready = head_mask & {PE_COUNT{!empty && out_free}};
  assign head_fire    = !empty && out_free && head_valid;
  assign pop          = head_fire && head_eop;

  // Output register: one beat of latency, payload held while stalled downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid <= 1'b0;
      commit_data  <= '0;
      commit_eop   <= 1'b0;
    end else if (out_free) begin
      commit_valid <= head_fire;
      if (head_fire) begin
        commit_data <= head_data;
        commit_eop  <= head_eop;
      end
    end
  end

`ifdef PE_SEQ_PERF_EN
  logic hol_stall;

  assign hol_stall = !empty && !head_valid && |(pe_rsp_valid & ~head_mask);

  // Saturating count of cycles where a non-head PE waits behind an idle head PE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_hol_stalls <= '0;
    end else if (hol_stall && (perf_hol_stalls != '1)) begin
      perf_hol_stalls <= perf_hol_stalls + PE_SEQ_PERF_W'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  logic [10:0] starve_cycles;

  // Tracks how long PE beats have been offered with nothing outstanding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cycles <= '0;
    end else if (empty && |pe_rsp_valid) begin
      if (starve_cycles != '1) begin
        starve_cycles <= starve_cycles + 11'd1;
      end
    end else begin
      starve_cycles <= '0;
    end
  end

  req_sel_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    (req_valid && req_ready) |-> req_in_range)
    else $error("pe_commit_sequencer: req_sel out of range, request not recorded");

  pe_beat_starved: assert property (@(posedge clk) disable iff (!reset_n)
    starve_cycles < 11'(PE_SEQ_STARVE_LIMIT))
    else $warning("pe_commit_sequencer: PE beat held with no outstanding request");
`endif

endmodule

// File: tb/tb_pe_commit_sequencer.sv
// Scoreboard bench for pe_commit_sequencer (PE_COUNT=4, ORDER_DEPTH=4, DATAW=64).
// Define PE_SEQ_PERF_EN to also exercise the head-of-line stall counter.
module tb_pe_commit_sequencer;

  localparam int PEC = 4;
  localparam int DW  = 64;
  localparam int OD  = 4;
  localparam int SW  = 2;
  localparam int CW  = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eop;
  } beat_t;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic [SW-1:0]     req_sel;
  logic              req_ready;
  logic [PEC-1:0]    pe_rsp_valid;
  logic [PEC*DW-1:0] pe_rsp_data;
  logic [PEC-1:0]    pe_rsp_eop;
  logic [PEC-1:0]    pe_rsp_ready;
  logic              commit_valid;
  logic [DW-1:0]     commit_data;
  logic              commit_eop;
  logic              commit_ready;
  logic [CW-1:0]     outstanding;
`ifdef PE_SEQ_PERF_EN
  logic [31:0]       perf_hol_stalls;
`endif

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  pe_commit_sequencer #(
    .PE_COUNT    (PEC),
    .DATAW       (DW),
    .ORDER_DEPTH (OD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .pe_rsp_valid (pe_rsp_valid),
    .pe_rsp_data  (pe_rsp_data),
    .pe_rsp_eop   (pe_rsp_eop),
    .pe_rsp_ready (pe_rsp_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_eop   (commit_eop),
    .commit_ready (commit_ready),
    .outstanding  (outstanding)
`ifdef PE_SEQ_PERF_EN
    ,
    .perf_hol_stalls (perf_hol_stalls)
`endif
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges despite the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: every accepted commit beat is matched against the oldest expected beat
  always @(negedge clk) begin
    if (reset_n && commit_valid && commit_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL commit_unexpected: got data=%0h eop=%0b, required no beat", commit_data, commit_eop);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (commit_data !== e.data || commit_eop !== e.eop) begin
          errors++;
          $display("[TB] FAIL commit_beat: got data=%0h eop=%0b, required data=%0h eop=%0b",
                   commit_data, commit_eop, e.data, e.eop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic e);
    beat_t b;
    b.data = d;
    b.eop  = e;
    exp_q.push_back(b);
  endtask

  task automatic issue(input logic [SW-1:0] sel);
    int n = 0;
    req_valid = 1'b1;
    req_sel   = sel;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL issue_ready_timeout: got req_ready=%0b, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input int p, input logic [DW-1:0] d, input logic e);
    int n = 0;
    pe_rsp_valid[p]          = 1'b1;
    pe_rsp_data[p*DW +: DW]  = d;
    pe_rsp_eop[p]            = e;
    #1;
    while (!pe_rsp_ready[p] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (pe_rsp_ready[p] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beat_ready_timeout pe%0d: got ready=%0b, required 1", p, pe_rsp_ready[p]);
    end
    tick();
    pe_rsp_valid[p] = 1'b0;
    pe_rsp_eop[p]   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d beats missing, required 0", exp_q.size());
    end
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("[TB] FAIL drain_outstanding: got %0d, required 0", outstanding);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset_n = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0 || outstanding !== 3'd0 || req_ready !== 1'b0 || pe_rsp_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got cv=%0b out=%0d rr=%0b prr=%b, required all 0",
               commit_valid, outstanding, req_ready, pe_rsp_ready);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %0b, required 1", req_ready);
    end
  endtask

  task automatic test_out_of_order();
    $display("[TB] test_out_of_order");
    issue(2'd2);
    issue(2'd0);
    checks++;
    if (outstanding !== 3'd2) begin
      errors++;
      $display("[TB] FAIL ooo_outstanding: got %0d, required 2", outstanding);
    end
    expect_beat(64'hB, 1'b1);
    expect_beat(64'hA, 1'b1);
    pe_rsp_valid[0]        = 1'b1;
    pe_rsp_data[0 +: DW]   = 64'hA;
    pe_rsp_eop[0]          = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (pe_rsp_ready !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL ooo_pe0_held: got pe_rsp_ready=%b, required 0100", pe_rsp_ready);
      end
      tick();
    end
    send_beat(2, 64'hB, 1'b1);
    checks++;
    if (pe_rsp_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL ooo_pe0_ready: got pe_rsp_ready=%b, required 0001", pe_rsp_ready);
    end
    tick();
    pe_rsp_valid[0] = 1'b0;
    pe_rsp_eop[0]   = 1'b0;
    drain();
  endtask

  task automatic test_full();
    $display("[TB] test_full");
    for (int i = 0; i < OD; i++) issue(2'd1);
    checks++;
    if (req_ready !== 1'b0 || outstanding !== 3'd4) begin
      errors++;
      $display("[TB] FAIL full_state: got rr=%0b out=%0d, required rr=0 out=4", req_ready, outstanding);
    end
    expect_beat(64'hC, 1'b1);
    pe_rsp_valid[1]       = 1'b1;
    pe_rsp_data[DW +: DW] = 64'hC;
    pe_rsp_eop[1]         = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || pe_rsp_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL full_pop_cycle: got rr=%0b prr=%b, required rr=0 prr=0010", req_ready, pe_rsp_ready);
    end
    tick();
    pe_rsp_valid[1] = 1'b0;
    pe_rsp_eop[1]   = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || outstanding !== 3'd3) begin
      errors++;
      $display("[TB] FAIL full_after_pop: got rr=%0b out=%0d, required rr=1 out=3", req_ready, outstanding);
    end
    expect_beat(64'hD, 1'b1);
    expect_beat(64'hE, 1'b1);
    expect_beat(64'hF, 1'b1);
    send_beat(1, 64'hD, 1'b1);
    send_beat(1, 64'hE, 1'b1);
    send_beat(1, 64'hF, 1'b1);
    drain();
  endtask

  task automatic test_multi_beat();
    logic [DW-1:0] vals [3];
    $display("[TB] test_multi_beat");
    vals[0] = 64'h1;
    vals[1] = 64'h2;
    vals[2] = 64'h3;
    issue(2'd1);
    for (int i = 0; i < 3; i++) expect_beat(vals[i], (i == 2));
    for (int i = 0; i < 3; i++) begin
      pe_rsp_valid[1]       = 1'b1;
      pe_rsp_data[DW +: DW] = vals[i];
      pe_rsp_eop[1]         = (i == 2);
      #1;
      checks++;
      if (pe_rsp_ready !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL multi_ready beat%0d: got %b, required 0010", i, pe_rsp_ready);
      end
      tick();
      if (i < 2) begin
        checks++;
        if (outstanding !== 3'd1) begin
          errors++;
          $display("[TB] FAIL multi_head_kept beat%0d: got out=%0d, required 1", i, outstanding);
        end
      end
    end
    pe_rsp_valid[1] = 1'b0;
    pe_rsp_eop[1]   = 1'b0;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("[TB] FAIL multi_pop: got out=%0d, required 0", outstanding);
    end
    drain();
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    commit_ready = 1'b0;
    issue(2'd3);
    expect_beat(64'h44, 1'b0);
    expect_beat(64'h55, 1'b1);
    pe_rsp_valid[3]         = 1'b1;
    pe_rsp_data[3*DW +: DW] = 64'h44;
    pe_rsp_eop[3]           = 1'b0;
    tick();
    pe_rsp_data[3*DW +: DW] = 64'h55;
    pe_rsp_eop[3]           = 1'b1;
    repeat (5) begin
      #1;
      checks++;
      if (commit_valid !== 1'b1 || commit_data !== 64'h44 || commit_eop !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: got cv=%0b data=%0h eop=%0b, required cv=1 data=44 eop=0",
                 commit_valid, commit_data, commit_eop);
      end
      checks++;
      if (pe_rsp_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bp_ready: got %b, required 0000", pe_rsp_ready);
      end
      tick();
    end
    commit_ready = 1'b1;
    #1;
    checks++;
    if (pe_rsp_ready !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b, required 1000", pe_rsp_ready);
    end
    tick();
    pe_rsp_valid[3] = 1'b0;
    pe_rsp_eop[3]   = 1'b0;
    drain();
  endtask

  task automatic test_reset_midstream();
    $display("[TB] test_reset_midstream");
    commit_ready = 1'b0;
    issue(2'd0);
    issue(2'd1);
    checks++;
    if (outstanding !== 3'd2) begin
      errors++;
      $display("[TB] FAIL mid_outstanding: got %0d, required 2", outstanding);
    end
    pe_rsp_valid[0]      = 1'b1;
    pe_rsp_data[0 +: DW] = 64'h77;
    pe_rsp_eop[0]        = 1'b0;
    tick();
    pe_rsp_valid[0] = 1'b0;
    checks++;
    if (commit_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_loaded: got cv=%0b, required 1", commit_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0 || outstanding !== 3'd0 || req_ready !== 1'b0 || pe_rsp_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL mid_async_reset: got cv=%0b out=%0d rr=%0b prr=%b, required all 0",
               commit_valid, outstanding, req_ready, pe_rsp_ready);
    end
    tick();
    reset_n      = 1'b1;
    commit_ready = 1'b1;
    issue(2'd2);
    expect_beat(64'h99, 1'b1);
    send_beat(2, 64'h99, 1'b1);
    drain();
  endtask

`ifdef PE_SEQ_PERF_EN
  task automatic test_perf();
    $display("[TB] test_perf");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (perf_hol_stalls !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got %0d, required 0", perf_hol_stalls);
    end
    issue(2'd3);
    pe_rsp_valid[1] = 1'b1;
    pe_rsp_eop[1]   = 1'b1;
    repeat (7) tick();
    pe_rsp_valid[1] = 1'b0;
    pe_rsp_eop[1]   = 1'b0;
    checks++;
    if (perf_hol_stalls !== 32'd7) begin
      errors++;
      $display("[TB] FAIL perf_count: got %0d, required 7", perf_hol_stalls);
    end
    tick();
    checks++;
    if (perf_hol_stalls !== 32'd7) begin
      errors++;
      $display("[TB] FAIL perf_idle_hold: got %0d, required 7", perf_hol_stalls);
    end
    expect_beat(64'h3C, 1'b1);
    send_beat(3, 64'h3C, 1'b1);
    drain();
  endtask
`endif

  // Scenario sequence
  initial begin
    reset_n      = 1'b1;
    req_valid    = 1'b0;
    req_sel      = '0;
    pe_rsp_valid = '0;
    pe_rsp_data  = '0;
    pe_rsp_eop   = '0;
    commit_ready = 1'b1;
    #1;
    test_reset();
    test_out_of_order();
    test_full();
    test_multi_beat();
    test_backpressure();
    test_reset_midstream();
`ifdef PE_SEQ_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
